// File: rtl/cmac_axis_tx_arb.sv
// cmac_axis_tx_arb: packet-atomic round-robin merge of NUM_CH AXIS sources onto the CMAC TX port,
// with a 2-entry registered output buffer, malformed-beat flagging and oversize truncation/drain.
module cmac_axis_tx_arb #(
   parameter int NUM_CH    = 2,
   parameter int DATA_W    = 512,
   parameter int MAX_BEATS = 256,
   parameter int CNT_W     = 32
) (
   input  logic                       aclk,
   input  logic                       aresetn,
   input  logic                       tx_enable,
   input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
   input  logic [NUM_CH*DATA_W/8-1:0] s_axis_tkeep,
   input  logic [NUM_CH-1:0]          s_axis_tvalid,
   input  logic [NUM_CH-1:0]          s_axis_tlast,
   input  logic [NUM_CH-1:0]          s_axis_tuser,
   output logic [NUM_CH-1:0]          s_axis_tready,
   output logic [DATA_W-1:0]          m_axis_tdata,
   output logic [DATA_W/8-1:0]        m_axis_tkeep,
   output logic                       m_axis_tvalid,
   output logic                       m_axis_tlast,
   output logic                       m_axis_tuser,
   input  logic                       m_axis_tready,
   output logic [2:0]                 grant_ch,
   output logic                       busy,
   output logic [NUM_CH*CNT_W-1:0]    pkt_cnt,
   output logic [15:0]                trunc_cnt
);
   localparam int KW = DATA_W/8;
   localparam int BW = $clog2(MAX_BEATS+1);
   typedef enum logic [1:0] {IDLE, XFER, DROP} state_t;
   typedef struct packed {
      logic [DATA_W-1:0] d;
      logic [KW-1:0]     k;
      logic              l;
      logic              u;
   } beat_t;
   state_t state_q, state_d;
   logic [2:0] grant_q, grant_d, nxt_ch;
   logic found, ch_rdy, acc, trunc, push, pop, vld_q, vld_d;
   logic [BW-1:0] beat_q, beat_d;
   logic [1:0] cnt_q, cnt_d;
   logic [DATA_W-1:0] sel_d;
   logic [KW-1:0] sel_k, kp1;
   logic sel_v, sel_l, sel_u;
   beat_t in_beat, head_q, head_d, tail_q, tail_d;
   logic [NUM_CH*CNT_W-1:0] pkt_q, pkt_d;
   logic [15:0] trunc_q, trunc_d;

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         state_q <= IDLE;
         grant_q <= 3'(NUM_CH-1);
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         beat_q  <= beat_d;
      end

   // round-robin search starts one past the last grant; lowest distance wins
   always_comb begin
      nxt_ch  = grant_q;
      found   = 1'b0;
      for (int i = NUM_CH; i >= 1; i--)
         if (s_axis_tvalid[(int'(grant_q) + i) % NUM_CH]) begin
            nxt_ch = 3'((int'(grant_q) + i) % NUM_CH);
            found  = 1'b1;
         end
      state_d = state_q;
      grant_d = grant_q;
      beat_d  = beat_q;
      if (state_q == IDLE) begin
         beat_d = '0;
         if (tx_enable && found) begin
            state_d = XFER;
            grant_d = nxt_ch;
         end
      end else if (acc) begin
         if (state_q == XFER) beat_d = beat_q + BW'(1);
         state_d = sel_l ? IDLE : trunc ? DROP : state_q;
      end
   end

   always_comb begin
      sel_d = '0;
      sel_k = '0;
      sel_v = 1'b0;
      sel_l = 1'b0;
      sel_u = 1'b0;
      s_axis_tready = '0;
      ch_rdy = state_q == XFER ? cnt_q < 2'd2 : state_q == DROP;
      for (int c = 0; c < NUM_CH; c++)
         if (grant_q == 3'(c)) begin
            sel_d = s_axis_tdata[c*DATA_W +: DATA_W];
            sel_k = s_axis_tkeep[c*KW +: KW];
            sel_v = s_axis_tvalid[c];
            sel_l = s_axis_tlast[c];
            sel_u = s_axis_tuser[c];
            s_axis_tready[c] = ch_rdy;
         end
      acc   = ch_rdy && sel_v;
      push  = acc && state_q == XFER;
      trunc = push && !sel_l && beat_q == BW'(MAX_BEATS-1);
      kp1   = sel_k + KW'(1);
      in_beat.d = sel_d;
      in_beat.k = sel_k;
      in_beat.l = sel_l || trunc;
      // a contiguous last-beat keep is 2^n-1, so k & (k+1) flags any hole
      in_beat.u = sel_u || (sel_l && sel_k == '0) || (!sel_l && sel_k != '1)
                  || (sel_l && |(sel_k & kp1)) || trunc;
   end

   always_comb begin
      pop    = vld_q && m_axis_tready;
      head_d = head_q;
      tail_d = tail_q;
      if (cnt_q == 2'd2 && pop) head_d = tail_q;
      else if (push && (cnt_q == 2'd0 || pop)) head_d = in_beat;
      if (push && cnt_q == 2'd1 && !pop) tail_d = in_beat;
      cnt_d   = cnt_q + 2'(push) - 2'(pop);
      vld_d   = cnt_d != 2'd0;
      pkt_d   = pkt_q;
      for (int c = 0; c < NUM_CH; c++)
         if (push && sel_l && grant_q == 3'(c))
            pkt_d[c*CNT_W +: CNT_W] = pkt_q[c*CNT_W +: CNT_W] + CNT_W'(1);
      trunc_d = trunc_q + 16'(trunc && trunc_q != 16'hFFFF);
   end

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         head_q  <= '0;
         tail_q  <= '0;
         cnt_q   <= '0;
         vld_q   <= 1'b0;
         pkt_q   <= '0;
         trunc_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         cnt_q   <= cnt_d;
         vld_q   <= vld_d;
         pkt_q   <= pkt_d;
         trunc_q <= trunc_d;
      end

   assign m_axis_tdata  = head_q.d;
   assign m_axis_tkeep  = head_q.k;
   assign m_axis_tlast  = head_q.l;
   assign m_axis_tuser  = head_q.u;
   assign m_axis_tvalid = vld_q;
   assign grant_ch      = grant_q;
   assign busy          = state_q != IDLE || vld_q;
   assign pkt_cnt       = pkt_q;
   assign trunc_cnt     = trunc_q;
endmodule

// File: tb/tb_cmac_axis_tx_arb.sv
// tb_cmac_axis_tx_arb: directed bench for cmac_axis_tx_arb (2 channels, 64-bit data, 6-beat packet limit).
module tb_cmac_axis_tx_arb;
   localparam int NC = 2, DW = 64, KW = 8, MB = 6, CW = 32;
   logic aclk = 1'b0, aresetn = 1'b0, tx_enable = 1'b0;
   logic [NC*DW-1:0] s_axis_tdata = '0;
   logic [NC*KW-1:0] s_axis_tkeep = '0;
   logic [NC-1:0] s_axis_tvalid = '0, s_axis_tlast = '0, s_axis_tuser = '0, s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic [KW-1:0] m_axis_tkeep;
   logic m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy;
   logic m_axis_tready = 1'b0;
   logic [2:0] grant_ch;
   logic [NC*CW-1:0] pkt_cnt;
   logic [15:0] trunc_cnt;

   cmac_axis_tx_arb #(.NUM_CH(NC), .DATA_W(DW), .MAX_BEATS(MB), .CNT_W(CW)) dut (
      .aclk(aclk), .aresetn(aresetn), .tx_enable(tx_enable),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
      .grant_ch(grant_ch), .busy(busy), .pkt_cnt(pkt_cnt), .trunc_cnt(trunc_cnt));

   typedef struct {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
      logic        u;
   } beat_t;
   beat_t sq[NC][$];
   logic [65:0] oq[$], eq[$];
   int ocyc[$];
   bit pend[NC];
   bit opend, trk, held_v;
   logic [65:0] held_d;
   int n_in, n_out, max_occ, rdy_viol, stall_viol, pidx, rdy_mode, cyc;
   int checks = 0, failures = 0;

   initial forever #5 aclk = ~aclk;
   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] bd(input int c, input int p, input int b);
      return (64'(c) << 16) | (64'(p) << 8) | 64'(b);
   endfunction

   task automatic push_beat(input int c, input int p, input int b, input logic [7:0] k, input logic l, input logic u);
      beat_t t;
      t.d = bd(c, p, b);
      t.k = k;
      t.l = l;
      t.u = u;
      sq[c].push_back(t);
   endtask

   task automatic add_pkt(input int c, input int p, input int n);
      for (int b = 0; b < n; b++) push_beat(c, p, b, 8'hFF, b == n-1, 1'b0);
   endtask

   task automatic expect_beat(input int c, input int p, input int b, input logic l, input logic u);
      eq.push_back({u, l, bd(c, p, b)});
   endtask

   task automatic expect_pkt(input int c, input int p, input int n);
      for (int b = 0; b < n; b++) expect_beat(c, p, b, b == n-1, 1'b0);
   endtask

   task automatic compare_out(input string tag);
      check({tag, ":nbeats"}, oq.size(), eq.size());
      for (int i = 0; i < eq.size(); i++)
         check($sformatf("%s:beat%0d", tag, i), i < oq.size() ? oq[i] : 'x, eq[i]);
      oq.delete();
      eq.delete();
      ocyc.delete();
   endtask

   task automatic drain(input string tag, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge aclk);
         #1;
         ok = sq[0].size() == 0 && sq[1].size() == 0 && !busy && !m_axis_tvalid;
      end
      check({tag, ":drained"}, ok, 1);
   endtask

   task automatic wait_sq(input string tag, input int c, input int lvl, input int budget);
      bit ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         @(negedge aclk);
         #1;
         ok = sq[c].size() <= lvl;
      end
      check({tag, ":reached"}, ok, 1);
   endtask

   // sources, sink readiness and output monitor, all acting between clock edges
   initial forever begin
      @(negedge aclk);
      if (aresetn) begin
         for (int c = 0; c < NC; c++)
            if (pend[c]) begin
               void'(sq[c].pop_front());
               if (trk) n_in++;
            end
         if (opend && trk) n_out++;
         m_axis_tready = rdy_mode == 0 ? 1'b1 : (pidx % 3 == 0);
         pidx++;
         for (int c = 0; c < NC; c++) begin
            if (sq[c].size() > 0) begin
               s_axis_tdata[c*DW +: DW] = sq[c][0].d;
               s_axis_tkeep[c*KW +: KW] = sq[c][0].k;
               s_axis_tlast[c]  = sq[c][0].l;
               s_axis_tuser[c]  = sq[c][0].u;
               s_axis_tvalid[c] = 1'b1;
            end else s_axis_tvalid[c] = 1'b0;
            pend[c] = s_axis_tvalid[c] && s_axis_tready[c];
         end
         if (trk) begin
            if (n_in - n_out > max_occ) max_occ = n_in - n_out;
            if (n_in - n_out == 2 && s_axis_tready[0]) rdy_viol++;
         end
         if (held_v && m_axis_tvalid && {m_axis_tuser, m_axis_tlast, m_axis_tdata} !== held_d) stall_viol++;
         held_v = m_axis_tvalid && !m_axis_tready;
         held_d = {m_axis_tuser, m_axis_tlast, m_axis_tdata};
         opend = m_axis_tvalid && m_axis_tready;
         if (opend) begin
            oq.push_back({m_axis_tuser, m_axis_tlast, m_axis_tdata});
            ocyc.push_back(cyc);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge aclk);
      #1;
      check("rst:tvalid", m_axis_tvalid, 0);
      check("rst:tdata", m_axis_tdata, 0);
      check("rst:grant", grant_ch, 1);
      check("rst:busy", busy, 0);
      check("rst:pkt_cnt", pkt_cnt, 0);
      check("rst:trunc", trunc_cnt, 0);
      check("rst:s_tready", s_axis_tready, 0);
      aresetn = 1'b1;
      tx_enable = 1'b1;

      // both channels backlogged: strict alternation with one idle cycle between packets
      add_pkt(0, 0, 4); add_pkt(1, 0, 4); add_pkt(0, 1, 4); add_pkt(1, 1, 4);
      expect_pkt(0, 0, 4); expect_pkt(1, 0, 4); expect_pkt(0, 1, 4); expect_pkt(1, 1, 4);
      drain("t1", 200);
      check("t1:gap_in_pkt", ocyc[1] - ocyc[0], 1);
      check("t1:gap_pkt01", ocyc[4] - ocyc[3], 2);
      check("t1:gap_pkt12", ocyc[8] - ocyc[7], 2);
      check("t1:gap_pkt23", ocyc[12] - ocyc[11], 2);
      compare_out("t1");
      check("t1:pkt_cnt", pkt_cnt, {32'd2, 32'd2});

      // sink backpressure 1,0,0 repeating
      pidx = 0; rdy_mode = 1; n_in = 0; n_out = 0; max_occ = 0; rdy_viol = 0; stall_viol = 0; trk = 1'b1;
      add_pkt(0, 2, 3);
      expect_pkt(0, 2, 3);
      drain("t2", 200);
      trk = 1'b0; rdy_mode = 0;
      compare_out("t2");
      check("t2:stall_stable", stall_viol, 0);
      check("t2:full_blocks", rdy_viol, 0);
      check("t2:max_occ", max_occ, 2);

      // 9-beat packet against a 6-beat limit, then a normal packet
      add_pkt(1, 3, 9); add_pkt(1, 4, 2);
      for (int b = 0; b < MB; b++) expect_beat(1, 3, b, b == MB-1, b == MB-1);
      expect_pkt(1, 4, 2);
      drain("t3", 200);
      compare_out("t3");
      check("t3:trunc_cnt", trunc_cnt, 1);
      check("t3:pkt_cnt", pkt_cnt, {32'd3, 32'd3});

      // tx_enable dropped mid-packet
      add_pkt(0, 5, 5); add_pkt(1, 5, 2);
      wait_sq("t4:beat2", 0, 3, 50);
      tx_enable = 1'b0;
      repeat (20) @(negedge aclk);
      #1;
      check("t4:beats_while_off", oq.size(), 5);
      check("t4:grant_while_off", grant_ch, 0);
      check("t4:busy_while_off", busy, 0);
      check("t4:ch1_waiting", sq[1].size(), 2);
      tx_enable = 1'b1;
      @(negedge aclk);
      #1;
      check("t4:regrant", grant_ch, 1);
      check("t4:busy_regrant", busy, 1);
      expect_pkt(0, 5, 5); expect_pkt(1, 5, 2);
      drain("t4", 200);
      compare_out("t4");

      // malformed keep patterns and source error marker
      push_beat(0, 6, 0, 8'hFF, 1'b0, 1'b0);
      push_beat(0, 6, 1, 8'h0F, 1'b0, 1'b0);
      push_beat(0, 6, 2, 8'h00, 1'b1, 1'b0);
      push_beat(0, 7, 0, 8'hFF, 1'b0, 1'b1);
      push_beat(0, 7, 1, 8'h0F, 1'b1, 1'b0);
      push_beat(0, 8, 0, 8'h05, 1'b1, 1'b0);
      expect_beat(0, 6, 0, 1'b0, 1'b0);
      expect_beat(0, 6, 1, 1'b0, 1'b1);
      expect_beat(0, 6, 2, 1'b1, 1'b1);
      expect_beat(0, 7, 0, 1'b0, 1'b1);
      expect_beat(0, 7, 1, 1'b1, 1'b0);
      expect_beat(0, 8, 0, 1'b1, 1'b1);
      drain("t5", 200);
      compare_out("t5");
      check("t5:pkt_cnt", pkt_cnt, {32'd4, 32'd7});

      // asynchronous reset in the middle of a packet
      add_pkt(0, 9, 5);
      wait_sq("t6:beat2", 0, 3, 50);
      aresetn = 1'b0;
      #1;
      check("t6:tvalid", m_axis_tvalid, 0);
      check("t6:tlast", m_axis_tlast, 0);
      check("t6:tdata", m_axis_tdata, 0);
      check("t6:busy", busy, 0);
      check("t6:grant", grant_ch, 1);
      check("t6:pkt_cnt", pkt_cnt, 0);
      check("t6:s_tready", s_axis_tready, 0);
      for (int c = 0; c < NC; c++) begin
         sq[c].delete();
         pend[c] = 1'b0;
      end
      s_axis_tvalid = '0;
      opend = 1'b0;
      held_v = 1'b0;
      oq.delete();
      ocyc.delete();
      repeat (2) @(negedge aclk);
      #1;
      aresetn = 1'b1;
      add_pkt(1, 10, 2); add_pkt(0, 11, 2);
      expect_pkt(0, 11, 2); expect_pkt(1, 10, 2);
      drain("t6", 200);
      compare_out("t6");
      check("t6:pkt_cnt_after", pkt_cnt, {32'd1, 32'd1});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/cmac_axis_tx_arb.md
Name: cmac_axis_tx_arb

Overview:
- N-channel, packet-atomic round-robin arbiter that merges several 512-bit AXI-Stream packet sources onto the single CMAC TX AXIS port (tx_axis_*).
- Typical sources: the ERNIC TX stream and the test packet generator.
- Adds output register buffering, packet-boundary enable gating, per-channel packet counters, malformed-beat flagging and an oversize-packet guard that truncates and drains runaway packets.

Parameters:
- NUM_CH, 2, number of input channels (1..8).
- DATA_W, 512, tdata width in bits; tkeep width is DATA_W/8.
- MAX_BEATS, 256, maximum beats per packet before forced truncation (>=2).
- CNT_W, 32, width of each per-channel packet counter.

Ports:
- aclk  in  1  clock; CMAC txusrclk2 domain.
- aresetn  in  1  asynchronous active-low reset.
- tx_enable  in  1  permits new grants; sampled only at packet boundaries.
- s_axis_tdata  in  NUM_CH*DATA_W  channel c at [c*DATA_W +: DATA_W].
- s_axis_tkeep  in  NUM_CH*DATA_W/8  per-channel byte enables.
- s_axis_tvalid  in  NUM_CH  per-channel valid.
- s_axis_tlast  in  NUM_CH  per-channel end of packet.
- s_axis_tuser  in  NUM_CH  per-channel error marker.
- s_axis_tready  out  NUM_CH  per-channel ready.
- m_axis_tdata  out  DATA_W  to CMAC tx_axis_tdata.
- m_axis_tkeep  out  DATA_W/8  to CMAC tx_axis_tkeep.
- m_axis_tvalid  out  1  to CMAC tx_axis_tvalid.
- m_axis_tlast  out  1  to CMAC tx_axis_tlast.
- m_axis_tuser  out  1  to CMAC tx_axis_tuser; 1 = abort/bad frame.
- m_axis_tready  in  1  from CMAC tx_axis_tready.
- grant_ch  out  3  currently/last granted channel index.
- busy  out  1  high in XFER/DROP or while output buffer is non-empty.
- pkt_cnt  out  NUM_CH*CNT_W  packets forwarded per channel; wraps to 0.
- trunc_cnt  out  16  total truncated packets; saturates at 0xFFFF.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; grant_ch=NUM_CH-1 so the first grant goes to ch0; counters 0; output buffer emptied.
- Reset mid-packet: the partial packet is discarded and no tlast is emitted.
- FSM IDLE:
  - s_axis_tready=0.
  - If tx_enable=1 and any s_axis_tvalid=1, grant the first valid channel searching from (grant_ch+1) mod NUM_CH upward with wrap; register it in grant_ch; go to XFER next cycle.
  - Consequence: one idle cycle between packets.
- FSM XFER:
  - s_axis_tready[grant_ch] = buffer has space; all other channels' tready=0.
  - A beat counter increments on each accepted beat.
  - Accepted beat with tlast: pkt_cnt[grant_ch]++; go to IDLE.
  - Accepted beat number MAX_BEATS without tlast: forward it with m_axis_tlast=1 and m_axis_tuser=1; trunc_cnt++; pkt_cnt not incremented; go to DROP.
- FSM DROP:
  - s_axis_tready[grant_ch]=1; accepted beats are discarded.
  - On accepted tlast, go to IDLE.
- tx_enable deassert never interrupts XFER or DROP; it only blocks the next grant.
- Output buffer:
  - 2-entry skid buffer; m_axis_* are driven from registers only.
  - Latency: input accept at cycle t gives m_axis_tvalid at t+1.
  - Full-rate throughput within a packet while m_axis_tready=1.
  - m_axis_* hold stable while tvalid=1 and tready=0.
  - Space = fewer than 2 entries occupied, or 1 entry occupied with m_axis_tready=1.
- tuser on each forwarded beat = s_axis_tuser | (tlast & tkeep==0) | (!tlast & tkeep != all ones) | truncation.
- Non-contiguous tkeep on a last beat (bit set above a clear bit) also sets tuser.
- NUM_CH=1: arbitration degenerates to channel 0; the IDLE bubble is still present.
- An input tvalid drop mid-packet is legal and produces an output bubble, not an error.

Test Plan:
- 2 ch, both continuously valid with 4-beat packets, m_axis_tready=1 -> output order ch0,ch1,ch0,ch1; 1 idle cycle between packets; pkt_cnt = {2,2} after 4 packets.
- ch0 sends 3-beat packet; m_axis_tready toggles 1,0,0,1,... -> no beat lost or duplicated; data stable while stalled; s_axis_tready[0] low within 1 cycle once buffer holds 2 entries.
- MAX_BEATS=4, ch1 sends 7-beat packet -> exactly 4 output beats, beat 4 has tlast=1 and tuser=1; 3 beats drained; trunc_cnt=1; pkt_cnt[1]=0; next packet forwarded normally.
- tx_enable deasserted on beat 2 of a 5-beat packet -> all 5 beats delivered; no new grant while low; grant resumes 1 cycle after re-assert.
- Last beat tkeep=0x0000_0000_0000_0000 and a mid-packet beat with tkeep=0x00FF... -> m_axis_tuser=1 on exactly those beats.
- aresetn pulsed low mid-packet -> all outputs 0 asynchronously; counters 0; after release the first grant is ch0 and a complete packet is delivered.
